// File: rtl/sme_match_collector.sv
// Match collector: FIFO-buffers matcher results for a valid/ready host; SME_MC_SUMMARY_EN adds per-pattern hit summaries.
// Latency 1 cycle (first-word-fall-through); out_ready stalls output only, so a push at full with no pop is dropped.

module sme_mc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdat,
  output logic [W-1:0]             rdat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     drop
);
  // Generic FWFT FIFO; "full" is judged after a same-cycle pop, and a push refused at full is reported on drop.
  // Latency 1 cycle from push to rdat; never stalls the writer, it drops instead.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);
  assign drop    = push && !do_push;
  assign rdat    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module sme_match_collector #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_pattern_no,
  input  logic [11:0] in_match_addr,
  input  logic        in_finish,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_type,
  output logic [3:0]  out_pattern,
  output logic [11:0] out_payload,
  output logic        out_last,
  output logic        overflow,
  output logic        done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [3:0]  pattern;
    logic [11:0] addr;
  } match_t;

`ifdef SME_MC_SUMMARY_EN
  typedef enum logic [1:0] {COLLECT, DRAIN, SUMMARY, DONE} state_t;
  logic [11:0] hit_cnt [16];
  logic [3:0]  sum_idx;
`else
  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;
`endif

  state_t          state;
  match_t          fifo_wdat, fifo_rdat;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_drop;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_side, drain_empty;

  assign fifo_side   = (state == COLLECT) || (state == DRAIN);
  assign fifo_wdat   = '{pattern: in_pattern_no, addr: in_match_addr};
  assign fifo_push   = (state == COLLECT) && in_valid;
  assign fifo_pop    = fifo_side && !fifo_empty && out_ready;
  assign drain_empty = fifo_empty || ((fifo_cnt == CW'(1)) && fifo_pop);
  assign done        = (state == DONE);

  sme_mc_fifo #(.W($bits(match_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdat  (fifo_wdat),
    .rdat  (fifo_rdat),
    .empty (fifo_empty),
    .cnt   (fifo_cnt),
    .drop  (fifo_drop)
  );

  always_comb begin
    out_valid   = 1'b0;
    out_type    = 1'b0;
    out_pattern = '0;
    out_payload = '0;
    out_last    = 1'b0;
    if (fifo_side && !fifo_empty) begin
      out_valid   = 1'b1;
      out_pattern = fifo_rdat.pattern;
      out_payload = fifo_rdat.addr;
    end
`ifdef SME_MC_SUMMARY_EN
    else if (state == SUMMARY) begin
      out_valid   = 1'b1;
      out_type    = 1'b1;
      out_pattern = sum_idx;
      out_payload = hit_cnt[sum_idx];
      out_last    = (sum_idx == 4'hF);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= COLLECT;
      overflow <= 1'b0;
`ifdef SME_MC_SUMMARY_EN
      sum_idx  <= '0;
`endif
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      case (state)
        COLLECT: if (in_finish) state <= DRAIN;
`ifdef SME_MC_SUMMARY_EN
        DRAIN:   if (drain_empty) state <= SUMMARY;
        SUMMARY: if (out_ready) begin
          if (sum_idx == 4'hF) state <= DONE;
          sum_idx <= sum_idx + 4'd1;
        end
`else
        DRAIN:   if (drain_empty) state <= DONE;
`endif
        default: ;
      endcase
    end
  end

`ifdef SME_MC_SUMMARY_EN
  // Counts every reported match, including those the FIFO had to drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) hit_cnt[i] <= '0;
    end else if ((state == COLLECT) && in_valid && (hit_cnt[in_pattern_no] != 12'hFFF)) begin
      hit_cnt[in_pattern_no] <= hit_cnt[in_pattern_no] + 12'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sme_match_collector.sv
// Randomized and directed bench for sme_match_collector against a queue-based reference model.
module tb_sme_match_collector;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_pattern_no = '0;
  logic [11:0] in_match_addr = '0;
  logic        in_finish = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_type, out_last, overflow, done;
  logic [3:0]  out_pattern;
  logic [11:0] out_payload;

  int checks = 0;
  int errors = 0;

  sme_match_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_pattern_no (in_pattern_no),
    .in_match_addr (in_match_addr),
    .in_finish     (in_finish),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_type      (out_type),
    .out_pattern   (out_pattern),
    .out_payload   (out_payload),
    .out_last      (out_last),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 collect, 1 drain, 2 summary, 3 done.
  logic [15:0] mq[$];
  int          phase = 0;
  int          sum_p = 0;
  int          hits[16];
  bit          m_ovf = 0;
`ifdef SME_MC_SUMMARY_EN
  localparam int AFTER_DRAIN = 2;
`else
  localparam int AFTER_DRAIN = 3;
`endif

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      phase = 0;
      sum_p = 0;
      m_ovf = 0;
      for (int i = 0; i < 16; i++) hits[i] = 0;
    end else begin
      case (phase)
        0: begin
          if (out_ready && mq.size() > 0) void'(mq.pop_front());
          if (in_valid) begin
            hits[int'(in_pattern_no)]++;
            if (mq.size() < DEPTH) mq.push_back({in_pattern_no, in_match_addr});
            else m_ovf = 1;
          end
          if (in_finish) phase = 1;
        end
        1: begin
          if (out_ready && mq.size() > 0) void'(mq.pop_front());
          if (mq.size() == 0) phase = AFTER_DRAIN;
        end
        2: if (out_ready) begin
          if (sum_p == 15) phase = 3;
          else sum_p++;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic        ev, et, el;
    logic [3:0]  ep;
    logic [11:0] epl;
    ev = 1'b0; et = 1'b0; el = 1'b0; ep = '0; epl = '0;
    if (phase < 2 && mq.size() > 0) begin
      ev  = 1'b1;
      ep  = mq[0][15:12];
      epl = mq[0][11:0];
    end else if (phase == 2) begin
      ev  = 1'b1;
      et  = 1'b1;
      ep  = sum_p[3:0];
      epl = (hits[sum_p] > 4095) ? 12'hFFF : hits[sum_p][11:0];
      el  = (sum_p == 15);
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check("done", {31'b0, done}, {31'b0, (phase == 3)});
    if (ev) begin
      check("out_type", {31'b0, out_type}, {31'b0, et});
      check("out_pattern", {28'b0, out_pattern}, {28'b0, ep});
      check("out_payload", {20'b0, out_payload}, {20'b0, epl});
      check("out_last", {31'b0, out_last}, {31'b0, el});
    end
  end

  task automatic step(input logic v, input logic [3:0] p, input logic [11:0] a,
                      input logic f, input logic r);
    in_valid = v; in_pattern_no = p; in_match_addr = a; in_finish = f; out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Drains to done with noisy matcher inputs, optionally pinning one summary count literally.
  task automatic drain_to_done(input int rdy_pct, input int watch_p, input int watch_cnt);
    for (int i = 0; i < 400 && !done; i++) begin
`ifdef SME_MC_SUMMARY_EN
      if (watch_p >= 0 && out_valid && out_type && int'(out_pattern) == watch_p)
        check("summary_count", {20'b0, out_payload}, watch_cnt[31:0]);
`endif
      step(1'($urandom_range(1)), 4'($urandom_range(15)), 12'($urandom_range(4095)),
           1'($urandom_range(1)), 1'($urandom_range(99) < rdy_pct));
    end
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_type", {31'b0, out_type}, 32'd0);
    check("rst_out_pattern", {28'b0, out_pattern}, 32'd0);
    check("rst_out_payload", {20'b0, out_payload}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // Single match then finish
    step(1'b1, 4'd3, 12'h01A, 1'b0, 1'b1);
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_type", {31'b0, out_type}, 32'd0);
    check("single_pattern", {28'b0, out_pattern}, 32'd3);
    check("single_addr", {20'b0, out_payload}, 32'h01A);
    step(1'b0, 4'd0, 12'd0, 1'b1, 1'b1);
    drain_to_done(100, 3, 1);
    step(1'b1, 4'd3, 12'h055, 1'b1, 1'b1);
    check("done_hold", {31'b0, done}, 32'd1);
    check("done_no_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd2, 12'(i), 1'b0, 1'b0);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_stable", {20'b0, out_payload}, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_order", {20'b0, out_payload}, i);
      step(1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
    end
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Overflow
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 4'd7, 12'(12'h100 + i), 1'b0, 1'b0);
      if (i == 15) check("ovf_before", {31'b0, overflow}, 32'd0);
      if (i == 16) check("ovf_after17", {31'b0, overflow}, 32'd1);
    end
    step(1'b0, 4'd0, 12'd0, 1'b1, 1'b1);
    drain_to_done(100, 7, 18);
    check("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Full with concurrent pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'd1, 12'(i), 1'b0, 1'b0);
    step(1'b1, 4'd1, 12'hABC, 1'b0, 1'b1);
    check("full_pop_ovf", {31'b0, overflow}, 32'd0);
    check("full_pop_head", {20'b0, out_payload}, 32'd1);
    step(1'b0, 4'd0, 12'd0, 1'b1, 1'b0);
    drain_to_done(60, 1, 17);

    // Finish together with a match, then a match during drain
    do_reset();
    step(1'b1, 4'd5, 12'h123, 1'b1, 1'b0);
    check("fin_same_valid", {31'b0, out_valid}, 32'd1);
    check("fin_same_addr", {20'b0, out_payload}, 32'h123);
    step(1'b1, 4'd5, 12'h124, 1'b0, 1'b0);
    check("drain_ignore_ovf", {31'b0, overflow}, 32'd0);
    drain_to_done(100, 5, 1);

    // Saturation
    do_reset();
    for (int i = 0; i < 4100; i++) step(1'b1, 4'd0, 12'(i), 1'b0, 1'b1);
    step(1'b0, 4'd0, 12'd0, 1'b1, 1'b1);
    drain_to_done(100, 0, 4095);

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'd9, 12'(i), 1'b0, 1'b0);
    step(1'b0, 4'd0, 12'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_payload", {20'b0, out_payload}, 32'd0);
    check("mid_rst_pattern", {28'b0, out_pattern}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    reset = 1'b1;

    // Randomized runs
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int i = 0; i < 150; i++)
        step(1'($urandom_range(99) < 60), 4'($urandom_range(15)), 12'($urandom_range(4095)),
             1'b0, 1'($urandom_range(99) < 20 + run * 12));
      step(1'($urandom_range(1)), 4'($urandom_range(15)), 12'($urandom_range(4095)),
           1'b1, 1'($urandom_range(1)));
      drain_to_done(70, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
